// File: rtl/riscv_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: opcodes, FSM states,
// instruction classes and the select/cause codes seen by the datapath.
package riscv_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_TRAP
  } state_e;

  typedef enum logic [3:0] {
    CLS_OP, CLS_OP_IMM, CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR,
    CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_FENCE, CLS_SYSTEM, CLS_NONE
  } instr_cls_e;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_TARGET = 2'd1;
  localparam logic [1:0] PC_JALR   = 2'd2;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;
  localparam logic [1:0] WB_IMM  = 2'd3;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_BUS     = 2'd1;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd2;
  localparam logic [1:0] CAUSE_SYSTEM  = 2'd3;

endpackage

// File: rtl/instr_class_decode.sv
// Combinational opcode/funct3 classifier; flags encodings the FSM must trap on.
module instr_class_decode
  import riscv_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  output instr_cls_e  cls,
  output logic        illegal
);

  // Map opcode to class, then reject reserved funct3 values per class.
  always_comb begin
    cls     = CLS_NONE;
    illegal = 1'b0;
    case (opcode)
      OPC_OP:     cls = CLS_OP;
      OPC_OP_IMM: cls = CLS_OP_IMM;
      OPC_LUI:    cls = CLS_LUI;
      OPC_AUIPC:  cls = CLS_AUIPC;
      OPC_JAL:    cls = CLS_JAL;
      OPC_FENCE:  cls = CLS_FENCE;
      OPC_SYSTEM: cls = CLS_SYSTEM;
      OPC_JALR: begin
        cls     = CLS_JALR;
        illegal = (funct3 != 3'd0);
      end
      OPC_LOAD: begin
        cls     = CLS_LOAD;
        illegal = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
      end
      OPC_STORE: begin
        cls     = CLS_STORE;
        illegal = (funct3 > 3'd2);
      end
      OPC_BRANCH: begin
        cls     = CLS_BRANCH;
        illegal = (funct3 == 3'd2) || (funct3 == 3'd3);
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I sequencer: fetch -> decode -> exec -> mem -> writeback.
// Optional macro PERF_CNT_EN adds cycle and retired-instruction counters;
// without it cycle_cnt/instret_cnt are tied to zero.
//
// state     | meaning
// IDLE      | post-reset, all strobes low, goes to FETCH
// FETCH     | instruction read at PC, IR loads on mem_ack
// DECODE    | classify, trap on illegal or SYSTEM
// EXEC      | ALU operation; branches/fences finish here
// MEM       | load/store data access at ALU address
// WB        | register write and PC update
// TRAP      | halted, cause held until reset
module multicycle_control
  import riscv_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             branch_taken,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             alu_a_sel,
  output logic             alu_b_sel,
  output logic [2:0]       imm_sel,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic             halted,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  localparam int TMO_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(MEM_TIMEOUT);

  state_e           state_q, state_d;
  instr_cls_e       cls;
  logic             illegal;
  logic [TMO_W-1:0] tmo_q;
  logic             tmo_hit;
  logic             tmo_load;
  logic [1:0]       cause_q, cause_d;

  instr_class_decode u_dec (
    .opcode  (opcode),
    .funct3  (funct3),
    .cls     (cls),
    .illegal (illegal)
  );

  // Down-counter loaded with the budget on entry to a wait state; the last
  // unacked cycle is the one where it reads 1.
  assign tmo_hit  = (MEM_TIMEOUT != 0) && (tmo_q == TMO_W'(1));
  assign tmo_load = ((state_d == ST_FETCH) && (state_q != ST_FETCH)) ||
                    ((state_d == ST_MEM)   && (state_q != ST_MEM));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Memory wait timer.
  always_ff @(posedge clk) begin
    if (!rst_n)
      tmo_q <= '0;
    else if (tmo_load)
      tmo_q <= TMO_LOAD;
    else if (((state_q == ST_FETCH) || (state_q == ST_MEM)) && !mem_ack)
      tmo_q <= tmo_q - TMO_W'(1);
  end

  // Trap cause captured on entry to TRAP and held until reset.
  always_ff @(posedge clk) begin
    if (!rst_n)
      cause_q <= CAUSE_NONE;
    else if ((state_d == ST_TRAP) && (state_q != ST_TRAP))
      cause_q <= cause_d;
  end

  assign trap_cause = cause_q;

  // Next state and per-state strobes/selects.
  always_comb begin
    state_d      = state_q;
    cause_d      = CAUSE_NONE;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = PC_PLUS4;
    alu_a_sel    = 1'b0;
    alu_b_sel    = 1'b0;
    imm_sel      = IMM_I;
    reg_we       = 1'b0;
    wb_sel       = WB_ALU;
    halted       = 1'b0;

    if ((state_q == ST_EXEC) || (state_q == ST_MEM)) begin
      case (cls)
        CLS_OP_IMM: alu_b_sel = 1'b1;
        CLS_JALR:   alu_b_sel = 1'b1;
        CLS_LOAD:   alu_b_sel = 1'b1;
        CLS_STORE: begin alu_b_sel = 1'b1; imm_sel = IMM_S; end
        CLS_BRANCH: imm_sel = IMM_B;
        CLS_LUI:   begin alu_b_sel = 1'b1; imm_sel = IMM_U; end
        CLS_AUIPC: begin alu_a_sel = 1'b1; alu_b_sel = 1'b1; imm_sel = IMM_U; end
        CLS_JAL:   begin alu_a_sel = 1'b1; alu_b_sel = 1'b1; imm_sel = IMM_J; end
        default: ;
      endcase
    end

    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        mem_req = 1'b1;
        ir_we   = mem_ack;
        if (mem_ack) state_d = ST_DECODE;
        else if (tmo_hit) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_BUS;
        end
      end
      ST_DECODE: begin
        if (illegal) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else if (cls == CLS_SYSTEM) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_SYSTEM;
        end else
          state_d = ST_EXEC;
      end
      ST_EXEC: begin
        case (cls)
          CLS_LOAD, CLS_STORE: state_d = ST_MEM;
          CLS_BRANCH: begin
            pc_we   = 1'b1;
            pc_sel  = branch_taken ? PC_TARGET : PC_PLUS4;
            state_d = ST_FETCH;
          end
          CLS_FENCE: begin
            pc_we   = 1'b1;
            state_d = ST_FETCH;
          end
          default: state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (cls == CLS_STORE);
        if (mem_ack) begin
          if (cls == CLS_STORE) begin
            pc_we   = 1'b1;
            state_d = ST_FETCH;
          end else
            state_d = ST_WB;
        end else if (tmo_hit) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_BUS;
        end
      end
      ST_WB: begin
        reg_we  = 1'b1;
        pc_we   = 1'b1;
        state_d = ST_FETCH;
        case (cls)
          CLS_LOAD: wb_sel = WB_LOAD;
          CLS_LUI:  wb_sel = WB_IMM;
          CLS_JAL:  begin wb_sel = WB_PC4; pc_sel = PC_TARGET; end
          CLS_JALR: begin wb_sel = WB_PC4; pc_sel = PC_JALR; end
          default: ;
        endcase
      end
      ST_TRAP: halted = 1'b1;
      default: state_d = ST_IDLE;
    endcase

    // A write landing on the reset edge would corrupt PC/regfile/IR.
    if (!rst_n) begin
      ir_we  = 1'b0;
      pc_we  = 1'b0;
      reg_we = 1'b0;
    end
  end

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] cyc_q, ret_q;

  // Free-running cycle and retirement counters, wrapping naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      cyc_q <= cyc_q + CNT_W'(1);
      if ((state_d == ST_FETCH) &&
          ((state_q == ST_EXEC) || (state_q == ST_MEM) || (state_q == ST_WB)))
        ret_q <= ret_q + CNT_W'(1);
    end
  end

  assign cycle_cnt   = cyc_q;
  assign instret_cnt = ret_q;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control with hand-computed expectations.
module tb_multicycle_control;

  localparam int CNT_W = 32;
  localparam logic [31:0] I_ADDI  = 32'h00500093;
  localparam logic [31:0] I_BEQ   = 32'h00208463;
  localparam logic [31:0] I_LW    = 32'h0000A103;
  localparam logic [31:0] I_SW    = 32'h0020A023;
  localparam logic [31:0] I_BADOP = 32'h0000007F;
  localparam logic [31:0] I_LDF7  = 32'h00007003;
  localparam logic [31:0] I_ECALL = 32'h00000073;
`ifdef PERF_CNT_EN
  localparam int EXP_INSTRET = 3;
  localparam int EXP_CYCLES  = 13;
`else
  localparam int EXP_INSTRET = 0;
  localparam int EXP_CYCLES  = 0;
`endif

  logic             clk = 1'b0;
  logic             rst_n, branch_taken, mem_ack;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic             mem_req, mem_we, mem_addr_sel, ir_we, pc_we;
  logic [1:0]       pc_sel, wb_sel, trap_cause;
  logic             alu_a_sel, alu_b_sel, reg_we, halted;
  logic [2:0]       imm_sel;
  logic [CNT_W-1:0] cycle_cnt, instret_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multicycle_control #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
    .branch_taken(branch_taken), .mem_ack(mem_ack), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_we(ir_we), .pc_we(pc_we),
    .pc_sel(pc_sel), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
    .imm_sel(imm_sel), .reg_we(reg_we), .wb_sel(wb_sel), .halted(halted),
    .trap_cause(trap_cause), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT in IDLE with rst_n released.
  task automatic reset_dut();
    rst_n   = 1'b0;
    mem_ack = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  // Entered in FETCH; returns one cycle into DECODE.
  task automatic do_fetch(input logic [31:0] ins, input int waits);
    opcode = ins[6:0];
    funct3 = ins[14:12];
    for (int i = 0; i < waits; i++) begin
      mem_ack = 1'b0;
      #1;
      chk("fetch_wait_req", mem_req, 1);
      chk("fetch_wait_irwe", ir_we, 0);
      cyc();
    end
    mem_ack = 1'b1;
    #1;
    chk("fetch_req", mem_req, 1);
    chk("fetch_addr_sel", mem_addr_sel, 0);
    chk("fetch_irwe", ir_we, 1);
    cyc();
    mem_ack = 1'b0;
  endtask

  task automatic trap_case(input logic [31:0] ins, input logic [1:0] cause);
    do_fetch(ins, 0);
    cyc();
    #1;
    chk("trap_halted", halted, 1);
    chk("trap_cause", trap_cause, cause);
    chk("trap_req", mem_req, 0);
    mem_ack = 1'b1;
    repeat (3) cyc();
    chk("trap_sticky_halted", halted, 1);
    chk("trap_sticky_cause", trap_cause, cause);
    chk("trap_sticky_irwe", ir_we, 0);
    reset_dut();
    #1;
    chk("trap_cleared_halted", halted, 0);
    chk("trap_cleared_cause", trap_cause, 0);
    cyc();
  endtask

  initial begin
    rst_n = 1'b0; opcode = '0; funct3 = '0; branch_taken = 1'b0; mem_ack = 1'b0;
    cyc();
    cyc();
    chk("rst_req", mem_req, 0);
    chk("rst_halted", halted, 0);
    chk("rst_cause", trap_cause, 0);
    chk("rst_cycle", cycle_cnt, 0);
    chk("rst_instret", instret_cnt, 0);
    rst_n = 1'b1;
    #1;
    chk("idle_outputs", {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel, alu_a_sel,
                         alu_b_sel, imm_sel, reg_we, wb_sel, halted}, 0);
    cyc();

    // ADDI, ack on first fetch cycle
    do_fetch(I_ADDI, 0);
    #1;
    chk("addi_dec_req", mem_req, 0);
    chk("addi_dec_pcwe", pc_we, 0);
    cyc(); #1;
    chk("addi_exec_bsel", alu_b_sel, 1);
    chk("addi_exec_imm", imm_sel, 0);
    chk("addi_exec_pcwe", pc_we, 0);
    chk("addi_exec_regwe", reg_we, 0);
    cyc(); #1;
    chk("addi_wb_regwe", reg_we, 1);
    chk("addi_wb_sel", wb_sel, 0);
    chk("addi_wb_pcwe", pc_we, 1);
    chk("addi_wb_pcsel", pc_sel, 0);
    chk("addi_wb_bsel", alu_b_sel, 0);
    cyc();

    // BEQ taken then not taken
    do_fetch(I_BEQ, 1);
    cyc();
    branch_taken = 1'b1;
    #1;
    chk("beq_t_pcwe", pc_we, 1);
    chk("beq_t_pcsel", pc_sel, 1);
    chk("beq_t_regwe", reg_we, 0);
    chk("beq_t_imm", imm_sel, 2);
    cyc();
    chk("beq_t_back_fetch", mem_req, 1);
    do_fetch(I_BEQ, 0);
    cyc();
    branch_taken = 1'b0;
    #1;
    chk("beq_nt_pcwe", pc_we, 1);
    chk("beq_nt_pcsel", pc_sel, 0);
    cyc();

    // LW with three data-wait cycles
    do_fetch(I_LW, 0);
    cyc(); #1;
    chk("lw_exec_req", mem_req, 0);
    cyc();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lw_mem_req", mem_req, 1);
      chk("lw_mem_addr", mem_addr_sel, 1);
      chk("lw_mem_we", mem_we, 0);
      chk("lw_mem_halted", halted, 0);
      cyc();
    end
    mem_ack = 1'b1;
    #1;
    chk("lw_mem_ack_req", mem_req, 1);
    chk("lw_mem_ack_regwe", reg_we, 0);
    cyc();
    mem_ack = 1'b0;
    #1;
    chk("lw_wb_regwe", reg_we, 1);
    chk("lw_wb_sel", wb_sel, 1);
    chk("lw_wb_req", mem_req, 0);
    cyc();

    // SW
    do_fetch(I_SW, 0);
    cyc(); #1;
    chk("sw_exec_imm", imm_sel, 1);
    cyc();
    mem_ack = 1'b1;
    #1;
    chk("sw_mem_we", mem_we, 1);
    chk("sw_mem_pcwe", pc_we, 1);
    chk("sw_mem_regwe", reg_we, 0);
    cyc();
    mem_ack = 1'b0;
    #1;
    chk("sw_back_fetch", mem_req, 1);
    chk("sw_fetch_addr", mem_addr_sel, 0);

    // Traps: illegal opcode, LOAD f3=7, ECALL
    trap_case(I_BADOP, 2);
    trap_case(I_LDF7, 2);
    trap_case(I_ECALL, 3);

    // Fetch timeout after 4 unacked cycles
    mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("tmo_wait_req", mem_req, 1);
      chk("tmo_wait_halted", halted, 0);
      cyc();
    end
    #1;
    chk("tmo_halted", halted, 1);
    chk("tmo_cause", trap_cause, 1);
    chk("tmo_req", mem_req, 0);
    reset_dut();
    cyc();
    do_fetch(I_ADDI, 3);
    #1;
    chk("tmo_edge_halted", halted, 0);
    chk("tmo_edge_dec_req", mem_req, 0);

    // Reset asserted while in MEM
    reset_dut();
    cyc();
    do_fetch(I_LW, 0);
    cyc();
    cyc(); #1;
    chk("rstmem_req_before", mem_req, 1);
    rst_n = 1'b0;
    #1;
    chk("rstmem_pcwe", pc_we, 0);
    cyc();
    chk("rstmem_req_after", mem_req, 0);
    chk("rstmem_addr_after", mem_addr_sel, 0);
    rst_n = 1'b1;

    // Three ADDIs from a fresh reset
    reset_dut();
    cyc();
    for (int k = 0; k < 3; k++) begin
      do_fetch(I_ADDI, 0);
      cyc();
      cyc();
      cyc();
    end
    chk("perf_instret", instret_cnt, EXP_INSTRET);
    chk("perf_cycles", cycle_cnt, EXP_CYCLES);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
